aom_ramp_shaper: RTL and testbench

Shapes the laser AOM drive between `laser_aom_ctrl` and `ad5445_config`. It consumes the enable/voltage pair that `laser_aom_ctrl` produces and slews the voltage toward the target with a programmable step and update interval. On an overload error from `aom_trig_overload` it immediately forces a safe voltage. It drives `ad5445_config` directly (`dac_out_en`, `dac_out`).

---
 rtl/aom_pkg.sv | 39 +++
 rtl/aom_ramp_step.sv | 27 ++
 rtl/aom_ramp_shaper.sv | 162 ++++++++++++++++
 tb/tb_aom_ramp_shaper.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aom_pkg.sv
// Shared types and constants for the laser AOM drive chain (ramp shaper and
// overload detector agree on state naming and event priority through here).
package aom_pkg;

  localparam int              VOL_W   = 12;
  localparam logic [VOL_W-1:0] VOL_MAX = 12'd4095;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRACK = 3'd1,
    ST_RAMP  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } aom_ramp_state_t;

  // Highest-ranked pending event; EVT_NONE lets the state's normal work proceed.
  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_RAMP_EN = 2'd1,
    EVT_EN_FALL = 2'd2,
    EVT_FAULT   = 2'd3
  } aom_evt_t;

  function automatic aom_evt_t aom_prio_evt(input logic err, input logic en_fall,
                                            input logic ramp_chg);
    aom_evt_t evt;
    if (err) begin
      evt = EVT_FAULT;
    end else if (en_fall) begin
      evt = EVT_EN_FALL;
    end else if (ramp_chg) begin
      evt = EVT_RAMP_EN;
    end else begin
      evt = EVT_NONE;
    end
    return evt;
  endfunction

endpackage

// File: rtl/aom_ramp_step.sv
// One slew step: moves cur toward tgt by at most max(step,1), never past tgt.
module aom_ramp_step
  import aom_pkg::*;
(
  input  logic [VOL_W-1:0] cur_i,
  input  logic [VOL_W-1:0] tgt_i,
  input  logic [VOL_W-1:0] step_i,
  output logic [VOL_W-1:0] next_o,
  output logic             at_target_o
);

  logic signed [VOL_W:0] diff_s;
  logic [VOL_W-1:0]      mag_s;
  logic [VOL_W-1:0]      step_eff_s;
  logic [VOL_W-1:0]      delta_s;

  // Clamping delta to |diff| keeps the result inside 0..VOL_MAX without wrap checks.
  always_comb begin
    diff_s      = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
    mag_s       = diff_s[VOL_W] ? VOL_W'(-diff_s) : diff_s[VOL_W-1:0];
    step_eff_s  = (step_i == 12'd0) ? 12'd1 : step_i;
    delta_s     = (step_eff_s < mag_s) ? step_eff_s : mag_s;
    next_o      = diff_s[VOL_W] ? (cur_i - delta_s) : (cur_i + delta_s);
    at_target_o = (next_o == tgt_i);
  end

endmodule

// File: rtl/aom_ramp_shaper.sv
// Slew-limits the AOM DAC code between laser_aom_ctrl and ad5445_config and
// forces a safe code on overload.
module aom_ramp_shaper
  import aom_pkg::*;
#(
  parameter real TCQ    = 0.1,
  parameter int  INTV_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              laser_aom_en_i,
  input  logic [VOL_W-1:0]  laser_aom_voltage_i,
  input  logic              ramp_en_i,
  input  logic [VOL_W-1:0]  ramp_step_i,
  input  logic [INTV_W-1:0] ramp_interval_i,
  input  logic [VOL_W-1:0]  safe_vol_i,
  input  logic              aom_continuous_trig_err_i,
  input  logic              aom_integral_trig_err_i,
  output logic              dac_out_en_o,
  output logic [VOL_W-1:0]  dac_out_o,
  output logic              ramp_busy_o,
  output logic              ramp_done_o
);

  // TCQ only shapes behavioural models of this block; the RTL itself is delay-free.
  if (TCQ < 0.0) begin : g_tcq_range
  end

  aom_ramp_state_t   state_q, state_d;
  logic [VOL_W-1:0]  dac_q, dac_d;
  logic [INTV_W-1:0] cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              err_s;
  logic              ramp_chg_s;
  aom_evt_t          evt_s;
  logic [INTV_W-1:0] intv_last_s;
  logic [VOL_W-1:0]  step_next_s;
  logic              at_tgt_s;

  assign err_s       = aom_continuous_trig_err_i | aom_integral_trig_err_i;
  assign ramp_chg_s  = (state_q == ST_TRACK) ? ramp_en_i : ~ramp_en_i;
  assign evt_s       = aom_prio_evt(err_s, ~laser_aom_en_i, ramp_chg_s);
  assign intv_last_s = (ramp_interval_i == {INTV_W{1'b0}}) ? {INTV_W{1'b0}}
                                                           : ramp_interval_i - INTV_W'(1);

  aom_ramp_step u_step (
    .cur_i       (dac_q),
    .tgt_i       (laser_aom_voltage_i),
    .step_i      (ramp_step_i),
    .next_o      (step_next_s),
    .at_target_o (at_tgt_s)
  );

  // Next-state and next-output decode; outputs reflect the state being entered.
  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (err_s) begin
          state_d = ST_FAULT;
          dac_d   = safe_vol_i;
        end else if (laser_aom_en_i && ramp_en_i) begin
          state_d = ST_RAMP;
          dac_d   = 12'd0;
          cnt_d   = {INTV_W{1'b0}};
        end else if (laser_aom_en_i) begin
          state_d = ST_TRACK;
          dac_d   = laser_aom_voltage_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRACK, ST_RAMP, ST_HOLD: begin
        case (evt_s)
          EVT_FAULT: begin
            state_d = ST_FAULT;
            dac_d   = safe_vol_i;
            cnt_d   = {INTV_W{1'b0}};
          end
          EVT_EN_FALL: begin
            state_d = ST_IDLE;
            cnt_d   = {INTV_W{1'b0}};
          end
          EVT_RAMP_EN: begin
            cnt_d = {INTV_W{1'b0}};
            if (state_q == ST_TRACK) begin
              state_d = ST_RAMP;
            end else begin
              state_d = ST_TRACK;
              dac_d   = laser_aom_voltage_i;
            end
          end
          default: begin
            if (state_q == ST_TRACK) begin
              dac_d = laser_aom_voltage_i;
            end else if (state_q == ST_HOLD) begin
              state_d = (laser_aom_voltage_i != dac_q) ? ST_RAMP : ST_HOLD;
            end else if (cnt_q >= intv_last_s) begin
              cnt_d = {INTV_W{1'b0}};
              dac_d = step_next_s;
              if (at_tgt_s) begin
                state_d = ST_HOLD;
                done_d  = 1'b1;
              end else begin
                state_d = ST_RAMP;
              end
            end else begin
              cnt_d = cnt_q + INTV_W'(1);
            end
          end
        endcase
      end
      ST_FAULT: begin
        // Release needs both the error gone and the upstream enable dropped.
        if (!err_s && !laser_aom_en_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
          dac_d   = safe_vol_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dac_d   = 12'd0;
        cnt_d   = {INTV_W{1'b0}};
      end
    endcase
    en_d   = (state_d != ST_IDLE);
    busy_d = (state_d == ST_RAMP);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      dac_q   <= 12'd0;
      cnt_q   <= {INTV_W{1'b0}};
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dac_out_en_o = en_q;
  assign dac_out_o    = dac_q;
  assign ramp_busy_o  = busy_q;
  assign ramp_done_o  = done_q;

endmodule

// File: tb/tb_aom_ramp_shaper.sv
// Scoreboard bench for aom_ramp_shaper: directed scenarios plus random episodes
// checked cycle by cycle against a behavioural model.
module tb_aom_ramp_shaper;

  localparam int INTV_W = 16;
  localparam int M_IDLE = 0, M_TRACK = 1, M_RAMP = 2, M_HOLD = 3, M_FAULT = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              en;
  logic [11:0]       tgt;
  logic              ramp;
  logic [11:0]       step;
  logic [INTV_W-1:0] intv;
  logic [11:0]       safe;
  logic              cerr;
  logic              ierr;
  logic              dac_out_en_o;
  logic [11:0]       dac_out_o;
  logic              ramp_busy_o;
  logic              ramp_done_o;

  always #5 clk_i = ~clk_i;

  aom_ramp_shaper #(.INTV_W(INTV_W)) dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .laser_aom_en_i            (en),
    .laser_aom_voltage_i       (tgt),
    .ramp_en_i                 (ramp),
    .ramp_step_i               (step),
    .ramp_interval_i           (intv),
    .safe_vol_i                (safe),
    .aom_continuous_trig_err_i (cerr),
    .aom_integral_trig_err_i   (ierr),
    .dac_out_en_o              (dac_out_en_o),
    .dac_out_o                 (dac_out_o),
    .ramp_busy_o               (ramp_busy_o),
    .ramp_done_o               (ramp_done_o)
  );

  typedef struct {
    int en;
    int dac;
    int busy;
    int done;
  } exp_t;

  exp_t exp_q[$];
  int   seen[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_mode = M_IDLE;
  int   m_dac  = 0;
  int   m_cycles = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference model: advances one clock using the currently driven inputs.
  task automatic model_step(output exp_t e);
    int per, stp, diff, mv, done;
    done = 0;
    per  = (intv == 0) ? 1 : int'(intv);
    stp  = (step == 0) ? 1 : int'(step);
    if (rst_i) begin
      m_mode = M_IDLE; m_dac = 0; m_cycles = 0;
    end else if (cerr || ierr) begin
      m_mode = M_FAULT; m_dac = int'(safe); m_cycles = 0;
    end else if (m_mode == M_IDLE) begin
      if (en && ramp) begin
        m_mode = M_RAMP; m_dac = 0; m_cycles = 0;
      end else if (en) begin
        m_mode = M_TRACK; m_dac = int'(tgt);
      end
    end else if (m_mode == M_FAULT) begin
      if (!en) m_mode = M_IDLE;
      else m_dac = int'(safe);
    end else if (!en) begin
      m_mode = M_IDLE; m_cycles = 0;
    end else if (m_mode == M_TRACK && ramp) begin
      m_mode = M_RAMP; m_cycles = 0;
    end else if (m_mode != M_TRACK && !ramp) begin
      m_mode = M_TRACK; m_dac = int'(tgt); m_cycles = 0;
    end else if (m_mode == M_TRACK) begin
      m_dac = int'(tgt);
    end else if (m_mode == M_HOLD) begin
      if (int'(tgt) != m_dac) begin
        m_mode = M_RAMP; m_cycles = 0;
      end
    end else begin
      m_cycles++;
      if (m_cycles == per) begin
        m_cycles = 0;
        diff = int'(tgt) - m_dac;
        mv   = (diff < 0) ? -diff : diff;
        if (stp < mv) mv = stp;
        m_dac = (diff < 0) ? m_dac - mv : m_dac + mv;
        if (m_dac == int'(tgt)) begin
          m_mode = M_HOLD; done = 1;
        end
      end
    end
    e.en   = (m_mode != M_IDLE) ? 1 : 0;
    e.dac  = m_dac;
    e.busy = (m_mode == M_RAMP) ? 1 : 0;
    e.done = done;
  endtask

  task automatic cycle();
    exp_t e;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  // Runs until ramp_done_o (stop_dac < 0) or dac_out_o == stop_dac, logging code changes.
  task automatic watch(input int budget, input int stop_dac, output int ncyc);
    int last;
    last = int'(dac_out_o);
    ncyc = 0;
    seen.delete();
    for (int k = 0; k < budget; k++) begin
      cycle();
      ncyc++;
      if (int'(dac_out_o) != last) begin
        seen.push_back(int'(dac_out_o));
        last = int'(dac_out_o);
      end
      if ((stop_dac < 0 && ramp_done_o) || (stop_dac >= 0 && int'(dac_out_o) == stop_dac)) return;
    end
    chk("watch_timeout", ncyc, -1);
  endtask

  task automatic chk_seq(input string name, input int req[$]);
    chk({name, "_len"}, seen.size(), req.size());
    for (int i = 0; i < req.size() && i < seen.size(); i++) chk(name, seen[i], req[i]);
  endtask

  task automatic restart(input int s, input int iv, input int t);
    rst_i = 1'b1; en = 1'b0; ramp = 1'b0; cerr = 1'b0; ierr = 1'b0;
    cycle();
    rst_i = 1'b0; step = 12'(s); intv = INTV_W'(iv); tgt = 12'(t);
    en = 1'b1; ramp = 1'b1;
    cycle();
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_en",   int'(dac_out_en_o), e.en);
        chk("sb_dac",  int'(dac_out_o),    e.dac);
        chk("sb_busy", int'(ramp_busy_o),  e.busy);
        chk("sb_done", int'(ramp_done_o),  e.done);
      end
    end
  end

  initial begin
    int n;
    int up_exp[$];
    rst_i = 1'b1; en = 1'b0; tgt = 12'd0; ramp = 1'b0; step = 12'd0;
    intv = '0; safe = 12'd0; cerr = 1'b0; ierr = 1'b0;
    cycle();
    cycle();
    chk("rst_dac", int'(dac_out_o), 0);
    chk("rst_en", int'(dac_out_en_o), 0);
    chk("rst_busy", int'(ramp_busy_o), 0);
    chk("rst_done", int'(ramp_done_o), 0);

    rst_i = 1'b0; en = 1'b1; tgt = 12'd2457;
    cycle();
    chk("pt_dac", int'(dac_out_o), 2457);
    chk("pt_en", int'(dac_out_en_o), 1);
    chk("pt_busy", int'(ramp_busy_o), 0);

    restart(100, 10, 1638);
    watch(400, -1, n);
    chk("up_cycles", n, 170);
    for (int k = 1; k <= 16; k++) up_exp.push_back(100 * k);
    up_exp.push_back(1638);
    chk_seq("up_val", up_exp);
    cycle();
    chk("up_done_single", int'(ramp_done_o), 0);
    chk("up_hold_busy", int'(ramp_busy_o), 0);
    chk("up_hold_dac", int'(dac_out_o), 1638);

    restart(100, 10, 1638);
    watch(400, 1200, n);
    tgt = 12'd819;
    watch(100, -1, n);
    chk_seq("retgt_val", '{1100, 1000, 900, 819});

    restart(100, 10, 1638);
    safe = 12'd0;
    watch(400, 500, n);
    ierr = 1'b1;
    cycle();
    chk("flt_dac", int'(dac_out_o), 0);
    chk("flt_busy", int'(ramp_busy_o), 0);
    ierr = 1'b0;
    cycle();
    cycle();
    chk("flt_latched_en", int'(dac_out_en_o), 1);
    en = 1'b0;
    cycle();
    chk("flt_release_en", int'(dac_out_en_o), 0);

    restart(0, 0, 3);
    watch(20, -1, n);
    chk("deg_cycles", n, 3);
    chk_seq("deg_val", '{1, 2, 3});

    restart(100, 10, 1638);
    watch(400, 500, n);
    rst_i = 1'b1;
    cycle();
    chk("mrst_dac", int'(dac_out_o), 0);
    chk("mrst_en", int'(dac_out_en_o), 0);
    chk("mrst_busy", int'(ramp_busy_o), 0);
    chk("mrst_done", int'(ramp_done_o), 0);
    rst_i = 1'b0;
    cycle();
    watch(50, 100, n);
    chk("mrst_restart", n, 10);

    for (int ep = 0; ep < 20; ep++) begin
      rst_i = 1'b1; cerr = 1'b0; ierr = 1'b0;
      cycle();
      rst_i = 1'b0; en = 1'b1; ramp = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: step = 12'd0;
        1: step = 12'($urandom_range(1, 64));
        default: step = 12'($urandom_range(500, 4095));
      endcase
      intv = INTV_W'($urandom_range(0, 4));
      safe = 12'($urandom_range(0, 4095));
      tgt  = 12'($urandom_range(0, 4095));
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 29) == 0) en = ~en;
        if ($urandom_range(0, 24) == 0) ramp = ~ramp;
        if ($urandom_range(0, 79) == 0) cerr = 1'b1;
        else if ($urandom_range(0, 3) == 0) cerr = 1'b0;
        if ($urandom_range(0, 79) == 0) ierr = 1'b1;
        else if ($urandom_range(0, 5) == 0) ierr = 1'b0;
        if ($urandom_range(0, 19) == 0) tgt = 12'($urandom_range(0, 4095));
        cycle();
      end
    end

    @(posedge clk_i);
    #3;
    chk("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
